charge_ctrl: RTL and testbench

CHARGE_CTRL -- requirements
Module: charge_ctrl

---
 rtl/charger_pkg.sv | 23 ++
 rtl/idle_timer.sv | 34 +++
 rtl/charge_ctrl.sv | 174 +++++++++++++++++
 tb/tb_charge_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/charger_pkg.sv
// Shared types and default parameters for the coin-operated charge controller.
package charger_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_LAUNCH   = 3'd2,
        S_CHARGING = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    localparam int PRICE_SEC_DEF  = 120;
    localparam int MAX_CREDIT_DEF = 99;
    localparam int IDLE_CYC_DEF   = 30000;
    localparam int IDLE_W         = 15;
    localparam int LAUNCH_WAIT    = 8;

    // Value in credit units of the coin pulses seen in one cycle.
    function automatic logic [2:0] coin_value(input logic c1, input logic c5);
        return {2'b00, c1} + (c5 ? 3'd5 : 3'd0);
    endfunction

endpackage

// File: rtl/idle_timer.sv
// COLLECT inactivity timer: down-counter reloaded on load, expire at terminal count.
module idle_timer
    import charger_pkg::*;
#(
    parameter int LOAD_VAL = IDLE_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    logic [IDLE_W-1:0] cnt_q, cnt_d;

    // Reload to LOAD_VAL-1 so expire rises on the LOAD_VAL-th cycle after a load.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = IDLE_W'(LOAD_VAL - 1);
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/charge_ctrl.sv
// Coin-operated charging controller: collects credit, launches the charge timer,
// handles refunds on cancel, inactivity or timer start failure.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no credit; first accepted coin moves to S_COLLECT
// S_COLLECT  | accumulating credit; cancel/timeout refunds, confirm launches
// S_LAUNCH   | start asserted, waiting up to LAUNCH_WAIT cycles for timing
// S_CHARGING | timer running; falling timing ends the charge
// S_DONE     | single cycle, done pulse, back to S_IDLE
module charge_ctrl
    import charger_pkg::*;
#(
    parameter int PRICE_SEC  = PRICE_SEC_DEF,
    parameter int MAX_CREDIT = MAX_CREDIT_DEF,
    parameter int IDLE_CYC   = IDLE_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        coin1,
    input  logic        coin5,
    input  logic        confirm,
    input  logic        cancel,
    input  logic        timing,
    output logic        start,
    output logic [13:0] charge_sec,
    output logic [6:0]  credit,
    output logic        refund,
    output logic [6:0]  refund_amt,
    output logic        coin_reject,
    output logic        done
);

    state_e      state_q, state_d;
    logic [6:0]  credit_q, credit_d;
    logic [6:0]  held_q, held_d;
    logic [13:0] charge_sec_q, charge_sec_d;
    logic [2:0]  launch_cnt_q, launch_cnt_d;
    logic        start_q, start_d;
    logic        refund_q, refund_d;
    logic [6:0]  refund_amt_q, refund_amt_d;
    logic        coin_reject_q, coin_reject_d;
    logic        done_q, done_d;

    logic        coin_any;
    logic [7:0]  coin_sum;
    logic        coin_fits;
    logic        timer_load;
    logic        timer_expire;

    idle_timer #(.LOAD_VAL(IDLE_CYC)) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .expire (timer_expire)
    );

    assign coin_any  = coin1 | coin5;
    assign coin_sum  = {1'b0, credit_q} + {5'b0, coin_value(coin1, coin5)};
    assign coin_fits = (coin_sum <= 8'(MAX_CREDIT));

    // Next-state and next-output logic; cancel beats confirm beats coin.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        held_d        = held_q;
        charge_sec_d  = charge_sec_q;
        launch_cnt_d  = launch_cnt_q;
        refund_d      = 1'b0;
        refund_amt_d  = '0;
        coin_reject_d = 1'b0;
        timer_load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (coin_any) begin
                    if (coin_fits) begin
                        credit_d   = coin_sum[6:0];
                        timer_load = 1'b1;
                        state_d    = S_COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (cancel || timer_expire) begin
                    refund_d      = 1'b1;
                    refund_amt_d  = credit_q;
                    credit_d      = '0;
                    coin_reject_d = coin_any;
                    state_d       = S_IDLE;
                end else if (confirm) begin
                    coin_reject_d = coin_any;
                    if (credit_q != '0) begin
                        charge_sec_d = 14'(credit_q) * 14'(PRICE_SEC);
                        held_d       = credit_q;
                        credit_d     = '0;
                        launch_cnt_d = 3'(LAUNCH_WAIT - 1);
                        state_d      = S_LAUNCH;
                    end
                end else if (coin_any) begin
                    if (coin_fits) begin
                        credit_d   = coin_sum[6:0];
                        timer_load = 1'b1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                coin_reject_d = coin_any;
                if (timing) begin
                    state_d = S_CHARGING;
                end else if (launch_cnt_q == '0) begin
                    refund_d     = 1'b1;
                    refund_amt_d = held_q;
                    state_d      = S_IDLE;
                end else begin
                    launch_cnt_d = launch_cnt_q - 1'b1;
                end
            end
            S_CHARGING: begin
                coin_reject_d = coin_any;
                if (!timing)
                    state_d = S_DONE;
            end
            S_DONE: begin
                coin_reject_d = coin_any;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        start_d = (state_d == S_LAUNCH) || (state_d == S_CHARGING);
        done_d  = (state_d == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            held_q        <= '0;
            charge_sec_q  <= '0;
            launch_cnt_q  <= '0;
            start_q       <= 1'b0;
            refund_q      <= 1'b0;
            refund_amt_q  <= '0;
            coin_reject_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            held_q        <= held_d;
            charge_sec_q  <= charge_sec_d;
            launch_cnt_q  <= launch_cnt_d;
            start_q       <= start_d;
            refund_q      <= refund_d;
            refund_amt_q  <= refund_amt_d;
            coin_reject_q <= coin_reject_d;
            done_q        <= done_d;
        end
    end

    assign start       = start_q;
    assign charge_sec  = charge_sec_q;
    assign credit      = credit_q;
    assign refund      = refund_q;
    assign refund_amt  = refund_amt_q;
    assign coin_reject = coin_reject_q;
    assign done        = done_q;

endmodule

// File: tb/tb_charge_ctrl.sv
// Bench for charge_ctrl: behavioural model compared every cycle plus directed literal checks.
module tb_charge_ctrl;

    localparam int PRICE = 120;
    localparam int MAXC  = 99;
    localparam int IDLEC = 30000;

    localparam int P_IDLE = 0, P_COLLECT = 1, P_LAUNCH = 2, P_CHARGING = 3, P_DONE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        coin1 = 1'b0, coin5 = 1'b0, confirm = 1'b0, cancel = 1'b0, timing = 1'b0;
    logic        start;
    logic [13:0] charge_sec;
    logic [6:0]  credit;
    logic        refund;
    logic [6:0]  refund_amt;
    logic        coin_reject;
    logic        done;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    charge_ctrl #(.PRICE_SEC(PRICE), .MAX_CREDIT(MAXC), .IDLE_CYC(IDLEC)) dut (
        .clk         (clk),
        .reset       (reset),
        .coin1       (coin1),
        .coin5       (coin5),
        .confirm     (confirm),
        .cancel      (cancel),
        .timing      (timing),
        .start       (start),
        .charge_sec  (charge_sec),
        .credit      (credit),
        .refund      (refund),
        .refund_amt  (refund_amt),
        .coin_reject (coin_reject),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase, credit ledger and elapsed-cycle counts.
    int m_phase = P_IDLE, m_credit = 0, m_charge = 0, m_idle = 0, m_wait = 0;
    int e_start = 0, e_refund = 0, e_amt = 0, e_rej = 0, e_done = 0;

    always @(posedge clk) begin
        int val;
        bit coin;
        val  = (coin1 ? 1 : 0) + (coin5 ? 5 : 0);
        coin = (val > 0);
        e_refund = 0; e_amt = 0; e_rej = 0; e_done = 0;
        if (reset) begin
            m_phase = P_IDLE; m_credit = 0; m_charge = 0; m_idle = 0; m_wait = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (coin) begin
                    if (m_credit + val <= MAXC) begin
                        m_credit += val; m_phase = P_COLLECT; m_idle = 0;
                    end else e_rej = 1;
                end
                P_COLLECT: begin
                    m_idle++;
                    if (cancel || m_idle >= IDLEC) begin
                        e_refund = 1; e_amt = m_credit; m_credit = 0;
                        m_phase = P_IDLE; e_rej = coin;
                    end else if (confirm) begin
                        e_rej = coin;
                        if (m_credit > 0) begin
                            m_charge = m_credit * PRICE; m_credit = 0;
                            m_phase = P_LAUNCH; m_wait = 0;
                        end
                    end else if (coin) begin
                        if (m_credit + val <= MAXC) begin
                            m_credit += val; m_idle = 0;
                        end else e_rej = 1;
                    end
                end
                P_LAUNCH: begin
                    e_rej = coin;
                    if (timing) m_phase = P_CHARGING;
                    else begin
                        m_wait++;
                        if (m_wait == 8) begin
                            e_refund = 1; e_amt = m_charge / PRICE; m_phase = P_IDLE;
                        end
                    end
                end
                P_CHARGING: begin
                    e_rej = coin;
                    if (!timing) begin m_phase = P_DONE; e_done = 1; end
                end
                default: begin
                    e_rej = coin; m_phase = P_IDLE;
                end
            endcase
        end
        e_start = (m_phase == P_LAUNCH || m_phase == P_CHARGING) ? 1 : 0;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("start", int'(start), e_start);
            check("credit", int'(credit), m_credit);
            check("charge_sec", int'(charge_sec), m_charge);
            check("refund", int'(refund), e_refund);
            if (refund || e_refund != 0) check("refund_amt", int'(refund_amt), e_amt);
            check("coin_reject", int'(coin_reject), e_rej);
            check("done", int'(done), e_done);
        end
    end

    task automatic drive(input logic c1, input logic c5, input logic cf, input logic cn);
        coin1 = c1; coin5 = c5; confirm = cf; cancel = cn;
        @(negedge clk);
        coin1 = 1'b0; coin5 = 1'b0; confirm = 1'b0; cancel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_credit", int'(credit), 0);
        check("rst_start", int'(start), 0);
        reset = 1'b0;
        idle(2);

        // Normal charge: 5+1+1 = 7 units -> 840 s.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("idle_confirm_ignored", int'(start), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("s1_credit", int'(credit), 7);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("s1_charge_sec", int'(charge_sec), 840);
        check("s1_start", int'(start), 1);
        timing = 1'b1;
        idle(5);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("s1_coin_in_charging_rej", int'(coin_reject), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("s1_cancel_ignored", int'(start), 1);
        timing = 1'b0;
        @(negedge clk);
        check("s1_done", int'(done), 1);
        check("s1_start_low", int'(start), 0);
        @(negedge clk);
        check("s1_done_one_cycle", int'(done), 0);
        idle(2);

        // Ceiling: 97 + 5 rejected, 97 + 1 accepted.
        repeat (19) drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("s2_credit97", int'(credit), 97);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("s2_reject", int'(coin_reject), 1);
        check("s2_credit_kept", int'(credit), 97);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("s2_credit98", int'(credit), 98);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("s2_refund_amt", int'(refund_amt), 98);
        idle(2);

        // Inactivity timeout.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!refund && n < IDLEC + 20) begin
            @(negedge clk);
            n++;
        end
        check("s3_timeout_cycles", n, IDLEC);
        check("s3_refund_amt", int'(refund_amt), 1);
        check("s3_credit", int'(credit), 0);
        idle(2);

        // Simultaneous coins, then cancel with a coin.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("s4_credit6", int'(credit), 6);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        check("s4_refund", int'(refund), 1);
        check("s4_refund_amt", int'(refund_amt), 6);
        check("s4_reject", int'(coin_reject), 1);
        idle(2);

        // Timer never starts: refund after 8 LAUNCH cycles.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (!refund && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("s5_wait_cycles", n, 8);
        check("s5_refund_amt", int'(refund_amt), 7);
        check("s5_start_low", int'(start), 0);
        idle(2);

        // Reset in the middle of a charge.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        timing = 1'b1;
        idle(4);
        check("s6_start_before", int'(start), 1);
        reset = 1'b1;
        @(negedge clk);
        check("s6_start", int'(start), 0);
        check("s6_charge_sec", int'(charge_sec), 0);
        check("s6_credit", int'(credit), 0);
        check("s6_refund", int'(refund), 0);
        check("s6_refund_amt", int'(refund_amt), 0);
        check("s6_done", int'(done), 0);
        reset = 1'b0;
        timing = 1'b0;
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
